spec_rotator: RTL and testbench
===============================

# spec_rotator

Parametrised spectrum rotator for the OFDM receive path: multiplies each complex I/Q sample by a per-sample unit phasor drawn from {1, j, -1, -j}, giving bypass, spectrum reversal (fs/2 shift), +fs/4 shift or -fs/4 shift. It sits between the front-end decimator and the FFT input buffer. It generalises the fixed fs/2 sign-alternator:
- configurable sample width;
- four runtime modes, latched at symbol boundaries;
- valid-strobe gating;
- phase re-alignment at each symbol start;
- saturating negation.

## Interface
Parameters:
- W, 14, sample width of in_i/in_q/out_i/out_q (two's complement, W ≥ 4)

Ports:
- clk  in  1  system clock; one clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  input sample valid; sample accepted on posedge when high
- sym_start  in  1  qualifies an accepted sample as first of a symbol; ignored when en=0
- mode  in  2  requested rotation: 0 bypass, 1 fs/2 reverse, 2 +fs/4, 3 -fs/4
- in_i, in_q  in  W each  signed input sample
- out_i, out_q  out  W each  signed rotated sample, registered
- out_valid  out  1  out_i/out_q hold a new sample this cycle
- sat  out  1  pulse: at least one component of the current output was clipped

## Operation
- State:
  - phase: 2-bit counter.
  - act_mode: 2-bit latched mode.
- Sample acceptance (en=1):
  - If sym_start=1, the sample uses phase 0 and the new mode value, and act_mode is updated to mode.
  - Otherwise the sample uses the current phase and act_mode.
  - After the sample, phase = (phase used + 1) mod 4, wrapping 3→0.
- Mode is applied only through act_mode. Changes on mode without sym_start have no effect.
- Rotation by phase p, giving (out_i, out_q):
  - Bypass: (i, q) for all p.
  - fs/2: p even → (i, q); p odd → (-i, -q).
  - +fs/4: p0 (i, q); p1 (-q, i); p2 (-i, -q); p3 (q, -i).
  - -fs/4: p0 (i, q); p1 (q, -i); p2 (-i, -q); p3 (-q, i).
- Negation saturates: -(-2^(W-1)) yields 2^(W-1)-1. All other values are exact.
- sat = 1 when either output component required that clip. Non-negated paths never saturate.
- en=0:
  - phase, act_mode, out_i and out_q hold.
  - out_valid = 0 and sat = 0 the next cycle.

## Timing
- Latency is 1 clock. Sample accepted at edge n appears on out_i/out_q with out_valid=1 after edge n.
- Throughput is one sample per clock. Back-to-back en is supported with no bubbles.
- Reset (asynchronous, immediate) sets: out_i=0, out_q=0, out_valid=0, sat=0, phase=0, act_mode=0 (bypass).
- Reset mid-symbol:
  - Samples after reset deassertion use bypass until the next sym_start.
  - phase restarts at 0.
- sym_start on consecutive accepted samples is legal. Each one re-zeroes phase, so all those samples use phase 0.
- mode and sym_start are sampled on the same edge as the data. There is no pre-load cycle.

## Structure
- Shared package spec_rot_pkg:
  - Mode encoding constants: MODE_BYP=0, MODE_REV=1, MODE_P4=2, MODE_M4=3.
  - 2-bit phase type.
- Sub-module sat_neg (parameter W): combinational saturating negate with a clip flag. Instantiated twice, once per component. Its output feeds a 4:1 select per component.
- The top level holds:
  - the phase counter;
  - the act_mode register;
  - the output register stage.

## Test plan
- Reset then en=0 → out_i=out_q=0, out_valid=0, sat=0. Then en=1 with mode=1 and sym_start=0 → output equals input (bypass still active).
- mode=1, sym_start on the first of 4 samples (100,-50),(100,-50),(100,-50),(100,-50) → (100,-50),(-100,50),(100,-50),(-100,50), each one cycle later.
- mode=2, sym_start, 5 samples (10,20) → (10,20),(-20,10),(-10,-20),(20,-10),(10,20); phase wraps. Repeat with mode=3 → p1 gives (20,-10).
- W=14, mode=1, odd-phase sample (-8192, 5) → (8191,-5) with sat=1. Sample (-8191, 0) → (8191, 0) with sat=0.
- mode switched 2→1 mid-symbol with no sym_start → +fs/4 sequence continues. At the next sym_start the reverse sequence begins at phase 0.
- Gaps: en toggled 1,0,0,1 in mode 2 → the second accepted sample uses phase 1, and out_valid is low in the gap cycles. rst asserted mid-stream → outputs zero immediately.

Source files
------------

// File: rtl/spec_rot_pkg.sv
// Shared definitions for the spectrum rotator: mode encodings, phase type and
// the mapping from (mode, phase) to the operand routed onto each output.
package spec_rot_pkg;

   localparam logic [1:0] MODE_BYP = 2'd0;
   localparam logic [1:0] MODE_REV = 2'd1;
   localparam logic [1:0] MODE_P4  = 2'd2;
   localparam logic [1:0] MODE_M4  = 2'd3;

   typedef logic [1:0] phase_t;

   // Operand routed to an output component: plain or negated I or Q
   typedef enum logic [1:0] {
      SEL_I  = 2'd0,
      SEL_NI = 2'd1,
      SEL_Q  = 2'd2,
      SEL_NQ = 2'd3
   } sel_t;

   typedef struct packed {
      sel_t i;
      sel_t q;
   } rot_sel_t;

   // Multiplication by j^k reduces to swapping and negating the components
   function automatic rot_sel_t rot_select(input logic [1:0] m, input phase_t p);
      rot_sel_t r;
      r.i = SEL_I;
      r.q = SEL_Q;
      case (m)
         MODE_REV: begin
            if (p[0]) begin
               r.i = SEL_NI;
               r.q = SEL_NQ;
            end
         end
         MODE_P4: begin
            case (p)
               2'd1: begin r.i = SEL_NQ; r.q = SEL_I;  end
               2'd2: begin r.i = SEL_NI; r.q = SEL_NQ; end
               2'd3: begin r.i = SEL_Q;  r.q = SEL_NI; end
               default: begin r.i = SEL_I; r.q = SEL_Q; end
            endcase
         end
         MODE_M4: begin
            case (p)
               2'd1: begin r.i = SEL_Q;  r.q = SEL_NI; end
               2'd2: begin r.i = SEL_NI; r.q = SEL_NQ; end
               2'd3: begin r.i = SEL_NQ; r.q = SEL_I;  end
               default: begin r.i = SEL_I; r.q = SEL_Q; end
            endcase
         end
         default: begin
            r.i = SEL_I;
            r.q = SEL_Q;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/spec_rotator_sat_neg.sv
// Combinational saturating two's complement negate; the most negative value
// maps to the most positive one and raises clip.
module sat_neg #(
   parameter int W = 14
) (
   input  logic signed [W-1:0] a,
   output logic signed [W-1:0] y,
   output logic                clip
);

   localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

   assign clip = (a == MINV);
   assign y    = clip ? MAXV : -a;

endmodule

// File: rtl/spec_rotator.sv
// Spectrum rotator: multiplies each accepted I/Q sample by a unit phasor from
// {1, j, -1, -j} chosen by the latched mode and a per-symbol phase counter.
module spec_rotator
   import spec_rot_pkg::*;
#(
   parameter int W = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sym_start,
   input  logic [1:0]          mode,
   input  logic signed [W-1:0] in_i,
   input  logic signed [W-1:0] in_q,
   output logic signed [W-1:0] out_i,
   output logic signed [W-1:0] out_q,
   output logic                out_valid,
   output logic                sat
);

   phase_t             phase;
   logic [1:0]         act_mode;
   logic [1:0]         use_mode;
   phase_t             use_phase;
   rot_sel_t           sel;
   logic signed [W-1:0] neg_i;
   logic signed [W-1:0] neg_q;
   logic               clip_i;
   logic               clip_q;
   logic signed [W-1:0] nxt_i;
   logic signed [W-1:0] nxt_q;
   logic               nxt_sat_i;
   logic               nxt_sat_q;

   sat_neg #(.W(W)) u_neg_i (
      .a    (in_i),
      .y    (neg_i),
      .clip (clip_i)
   );

   sat_neg #(.W(W)) u_neg_q (
      .a    (in_q),
      .y    (neg_q),
      .clip (clip_q)
   );

   // A symbol start takes effect on its own sample, so mode and phase bypass the registers
   always_comb begin
      use_mode  = sym_start ? mode : act_mode;
      use_phase = sym_start ? phase_t'(2'd0) : phase;
      sel       = rot_select(use_mode, use_phase);
   end

   always_comb begin
      nxt_i     = in_i;
      nxt_sat_i = 1'b0;
      case (sel.i)
         SEL_NI: begin
            nxt_i     = neg_i;
            nxt_sat_i = clip_i;
         end
         SEL_Q:  nxt_i = in_q;
         SEL_NQ: begin
            nxt_i     = neg_q;
            nxt_sat_i = clip_q;
         end
         default: nxt_i = in_i;
      endcase
   end

   always_comb begin
      nxt_q     = in_q;
      nxt_sat_q = 1'b0;
      case (sel.q)
         SEL_I:  nxt_q = in_i;
         SEL_NI: begin
            nxt_q     = neg_i;
            nxt_sat_q = clip_i;
         end
         SEL_NQ: begin
            nxt_q     = neg_q;
            nxt_sat_q = clip_q;
         end
         default: nxt_q = in_q;
      endcase
   end

   // Data, mode and phase all hold while en is low; only the strobes drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase     <= '0;
         act_mode  <= MODE_BYP;
         out_i     <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
      end else if (en) begin
         phase     <= use_phase + 2'd1;
         act_mode  <= use_mode;
         out_i     <= nxt_i;
         out_q     <= nxt_q;
         out_valid <= 1'b1;
         sat       <= nxt_sat_i | nxt_sat_q;
      end else begin
         out_valid <= 1'b0;
         sat       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spec_rotator.sv
// Randomised and directed bench for spec_rotator: a phasor-multiply reference
// model fills a per-cycle scoreboard that a monitor drains one clock later.
module tb_spec_rotator;

   localparam int W    = 14;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));

   typedef struct {
      bit v;
      int i;
      int q;
      bit s;
   } entry_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en = 1'b0;
   logic                symStart = 1'b0;
   logic [1:0]          mode = 2'd0;
   logic signed [W-1:0] inI = '0;
   logic signed [W-1:0] inQ = '0;
   logic signed [W-1:0] outI;
   logic signed [W-1:0] outQ;
   logic                outValid;
   logic                sat;

   entry_t expQ[$];
   int checks = 0;
   int errors = 0;

   int mPhase = 0;
   int mMode = 0;
   int lastI = 0;
   int lastQ = 0;
   int cosTab[4] = '{1, 0, -1, 0};
   int sinTab[4] = '{0, 1, 0, -1};

   spec_rotator #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sym_start (symStart),
      .mode      (mode),
      .in_i      (inI),
      .in_q      (inQ),
      .out_i     (outI),
      .out_q     (outQ),
      .out_valid (outValid),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int clipVal(input int x, output bit c);
      c = 1'b0;
      if (x > MAXV) begin
         c = 1'b1;
         return MAXV;
      end
      if (x < MINV) begin
         c = 1'b1;
         return MINV;
      end
      return x;
   endfunction

   // Reference: output = input * j^k with k from mode and phase, then clipped to W bits
   function automatic entry_t modelStep(input bit e, input bit ss, input int md, input int i, input int q);
      entry_t r;
      int p, k, re, im;
      bit ci, cq;
      r.v = e;
      r.s = 1'b0;
      if (!e) begin
         r.i = lastI;
         r.q = lastQ;
         return r;
      end
      if (ss) begin
         mMode = md;
         p = 0;
      end else begin
         p = mPhase;
      end
      case (mMode)
         1: k = (2 * p) % 4;
         2: k = p;
         3: k = (4 - p) % 4;
         default: k = 0;
      endcase
      re = i * cosTab[k] - q * sinTab[k];
      im = i * sinTab[k] + q * cosTab[k];
      r.i = clipVal(re, ci);
      r.q = clipVal(im, cq);
      r.s = ci | cq;
      mPhase = (p + 1) % 4;
      lastI = r.i;
      lastQ = r.q;
      return r;
   endfunction

   task automatic applyStimulus(input bit e, input bit ss, input int md, input int i, input int q);
      entry_t x;
      @(negedge clk);
      en       = e;
      symStart = ss;
      mode     = md[1:0];
      inI      = i[W-1:0];
      inQ      = q[W-1:0];
      x = modelStep(e, ss, md, i, q);
      expQ.push_back(x);
   endtask

   task automatic applyReset();
      @(negedge clk);
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_out_i", int'(outI), 0);
      checkOutput("rst_out_q", int'(outQ), 0);
      checkOutput("rst_valid", int'(outValid), 0);
      checkOutput("rst_sat", int'(sat), 0);
      expQ.delete();
      mPhase = 0;
      mMode = 0;
      lastI = 0;
      lastQ = 0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   function automatic int randSample();
      int r;
      if ($urandom_range(7) == 0) return MINV;
      r = int'($urandom_range((1 << W) - 1));
      return r - (1 << (W - 1));
   endfunction

   // Monitor: one scoreboard entry per driven cycle, compared just after the edge
   always @(posedge clk) begin
      entry_t x;
      #1;
      if (!rst) begin
         if (expQ.size() > 0) begin
            x = expQ.pop_front();
            checkOutput("out_valid", int'(outValid), int'(x.v));
            checkOutput("out_i", int'(outI), x.i);
            checkOutput("out_q", int'(outQ), x.q);
            checkOutput("sat", int'(sat), int'(x.s));
         end else if (outValid) begin
            checkOutput("spurious_valid", int'(outValid), 0);
         end
      end
   end

   initial begin
      int waitCount;
      $display("[TB] start");
      #12;
      checkOutput("init_out_i", int'(outI), 0);
      checkOutput("init_valid", int'(outValid), 0);
      checkOutput("init_sat", int'(sat), 0);
      @(negedge clk);
      #2 rst = 1'b0;

      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 123, -77);

      applyStimulus(1, 1, 1, 100, -50);
      for (int n = 0; n < 3; n++) applyStimulus(1, 0, 1, 100, -50);

      applyStimulus(1, 1, 2, 10, 20);
      for (int n = 0; n < 4; n++) applyStimulus(1, 0, 2, 10, 20);
      applyStimulus(1, 1, 3, 10, 20);
      for (int n = 0; n < 4; n++) applyStimulus(1, 0, 3, 10, 20);

      applyStimulus(1, 1, 1, 1, 1);
      applyStimulus(1, 0, 1, -8192, 5);
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(1, 0, 1, -8191, 0);
      applyStimulus(1, 1, 2, 7, -8192);
      applyStimulus(1, 0, 2, 7, -8192);

      applyStimulus(1, 1, 2, 300, 40);
      applyStimulus(1, 0, 2, 300, 40);
      applyStimulus(1, 0, 1, 300, 40);
      applyStimulus(1, 0, 1, 300, 40);
      applyStimulus(1, 1, 1, 300, 40);
      applyStimulus(1, 0, 1, 300, 40);
      applyStimulus(1, 1, 1, 5, 6);
      applyStimulus(1, 1, 1, 5, 6);

      applyStimulus(1, 1, 2, 11, 22);
      applyStimulus(0, 0, 2, 99, 99);
      applyStimulus(0, 0, 2, 99, 99);
      applyStimulus(1, 0, 2, 11, 22);

      applyStimulus(1, 1, 3, 33, 44);
      applyStimulus(1, 0, 3, 33, 44);
      applyReset();
      applyStimulus(1, 0, 2, 55, 66);
      applyStimulus(1, 0, 2, 55, 66);

      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(3) != 0, $urandom_range(4) == 0,
                       int'($urandom_range(3)), randSample(), randSample());
      end
      applyStimulus(0, 0, 0, 0, 0);

      waitCount = 0;
      while (expQ.size() > 0 && waitCount < 20) begin
         @(posedge clk);
         waitCount++;
      end
      #2;
      checkOutput("drain_pending", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
